// File: rtl/hitomezashi_pkg.sv
// Shared types and default start vectors for the Hitomezashi stitch generator.
// Vectors are declared [0:N-1] so index 0 is the MSB, i.e. column/row 0.
package hitomezashi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_V = 2'd1,
    LOAD_H = 2'd2,
    PEND   = 2'd3
  } load_state_t;

  localparam logic [0:39] V_INIT_DEF = 40'b0110000101001101001110101101010111101101;
  localparam logic [0:21] H_INIT_DEF = 22'b1011101001000011010000;

endpackage

// File: rtl/hitomezashi_loader.sv
// Serial start-vector loader: fills the shadow vectors bit by bit and raises
// a commit strobe on the first frame pulse once both vectors are complete.
module hitomezashi_loader
  import hitomezashi_pkg::*;
#(
  parameter int V_LINES = 40,
  parameter int H_LINES = 22
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load_start,
  input  logic               i_load_valid,
  input  logic               i_load_bit,
  input  logic               i_frame,
  output logic               o_load_ready,
  output logic               o_busy,
  output logic               o_commit,
  output logic [0:V_LINES-1] o_shadow_v,
  output logic [0:H_LINES-1] o_shadow_h
);

  localparam int CNTW  = $clog2(V_LINES > H_LINES ? V_LINES : H_LINES);
  localparam int VIDXW = $clog2(V_LINES);
  localparam int HIDXW = $clog2(H_LINES);

  load_state_t        r_state;
  load_state_t        w_state_nxt;
  logic [CNTW-1:0]    r_cnt;
  logic [0:V_LINES-1] r_shadow_v;
  logic [0:H_LINES-1] r_shadow_h;
  logic               w_last_v;
  logic               w_last_h;

  assign w_last_v = (r_cnt == CNTW'(V_LINES - 1));
  assign w_last_h = (r_cnt == CNTW'(H_LINES - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    o_load_ready = 1'b0;
    o_busy       = 1'b0;
    o_commit     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_load_start) w_state_nxt = LOAD_V;
      end
      LOAD_V: begin
        o_load_ready = 1'b1;
        o_busy       = 1'b1;
        if (i_load_valid && w_last_v) w_state_nxt = LOAD_H;
      end
      LOAD_H: begin
        o_load_ready = 1'b1;
        o_busy       = 1'b1;
        if (i_load_valid && w_last_h) w_state_nxt = PEND;
      end
      PEND: begin
        o_busy = 1'b1;
        if (i_frame) begin
          o_commit    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ready is high in both LOAD states, so valid alone marks an accepted bit
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt      <= '0;
      r_shadow_v <= '0;
      r_shadow_h <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_load_start) r_cnt <= '0;
        end
        LOAD_V: begin
          if (i_load_valid) begin
            r_shadow_v[r_cnt[VIDXW-1:0]] <= i_load_bit;
            r_cnt <= w_last_v ? '0 : r_cnt + 1'b1;
          end
        end
        LOAD_H: begin
          if (i_load_valid) begin
            r_shadow_h[r_cnt[HIDXW-1:0]] <= i_load_bit;
            r_cnt <= w_last_h ? '0 : r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_shadow_v = r_shadow_v;
  assign o_shadow_h = r_shadow_h;

endmodule

// File: rtl/hitomezashi_gen.sv
// Hitomezashi stitch-pattern generator: maps sx/sy to a registered stitch flag,
// with runtime-loadable start vectors committed at frame start and optional rotation.
module hitomezashi_gen
  import hitomezashi_pkg::*;
#(
  parameter int               CORDW     = 12,
  parameter int               CELL_LOG2 = 5,
  parameter int               V_LINES   = 40,
  parameter int               H_LINES   = 22,
  parameter logic [0:V_LINES-1] V_INIT  = V_INIT_DEF,
  parameter logic [0:H_LINES-1] H_INIT  = H_INIT_DEF,
  parameter int               ANIMW     = 8
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  input  logic             frame,
  input  logic             anim_en,
  input  logic [ANIMW-1:0] anim_div,
  input  logic             load_start,
  input  logic             load_valid,
  input  logic             load_bit,
  output logic             load_ready,
  output logic             load_done,
  output logic             busy,
  output logic             stitch
);

  localparam int CXW = CORDW - CELL_LOG2;

  logic [0:V_LINES-1] w_shadow_v;
  logic [0:H_LINES-1] w_shadow_h;
  logic               w_commit;
  logic [0:V_LINES-1] r_v_act;
  logic [0:H_LINES-1] r_h_act;
  logic [ANIMW-1:0]   r_frame_cnt;
  logic               r_load_done;
  logic               r_stitch;
  logic [CXW-1:0]     w_cx;
  logic [CXW-1:0]     w_cy;
  logic               w_v_bit;
  logic               w_h_bit;
  logic               w_v_line;
  logic               w_h_line;
  logic               w_v_on;
  logic               w_h_on;

  hitomezashi_loader #(
    .V_LINES (V_LINES),
    .H_LINES (H_LINES)
  ) u_loader (
    .i_clk        (clk_pix),
    .i_rst        (rst_pix),
    .i_load_start (load_start),
    .i_load_valid (load_valid),
    .i_load_bit   (load_bit),
    .i_frame      (frame),
    .o_load_ready (load_ready),
    .o_busy       (busy),
    .o_commit     (w_commit),
    .o_shadow_v   (w_shadow_v),
    .o_shadow_h   (w_shadow_h)
  );

  // commit and rotation both happen only on frame, so a frame never tears
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      r_v_act     <= V_INIT;
      r_h_act     <= H_INIT;
      r_frame_cnt <= '0;
      r_load_done <= 1'b0;
    end else begin
      r_load_done <= w_commit;
      if (w_commit) begin
        r_v_act     <= w_shadow_v;
        r_h_act     <= w_shadow_h;
        r_frame_cnt <= '0;
      end else if (!anim_en) begin
        r_frame_cnt <= '0;
      end else if (frame) begin
        if (r_frame_cnt == anim_div) begin
          r_frame_cnt <= '0;
          r_v_act     <= {r_v_act[1:V_LINES-1], r_v_act[0]};
          r_h_act     <= {r_h_act[1:H_LINES-1], r_h_act[0]};
        end else begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end
    end
  end

  assign w_cx = sx[CORDW-1:CELL_LOG2];
  assign w_cy = sy[CORDW-1:CELL_LOG2];

  // explicit mux so cells past the last line read 0 without an out-of-range select
  always_comb begin
    w_v_bit = 1'b0;
    w_h_bit = 1'b0;
    for (int i = 0; i < V_LINES; i++)
      if (w_cx == CXW'(i)) w_v_bit = r_v_act[i];
    for (int j = 0; j < H_LINES; j++)
      if (w_cy == CXW'(j)) w_h_bit = r_h_act[j];
  end

  assign w_v_line = (sx[CELL_LOG2-1:0] == '0);
  assign w_h_line = (sy[CELL_LOG2-1:0] == '0);
  assign w_v_on   = sy[CELL_LOG2] ^ w_v_bit;
  assign w_h_on   = sx[CELL_LOG2] ^ w_h_bit;

  always_ff @(posedge clk_pix) begin
    if (rst_pix) r_stitch <= 1'b0;
    else         r_stitch <= (w_v_line & w_v_on) | (w_h_line & w_h_on);
  end

  assign load_done = r_load_done;
  assign stitch    = r_stitch;

endmodule

// File: tb/tb_hitomezashi_gen.sv
// Directed/randomized bench for hitomezashi_gen against a queue-based pattern model.
module tb_hitomezashi_gen;

  logic        clk_pix = 1'b0;
  logic        rst_pix;
  logic [11:0] sx, sy;
  logic        frame, anim_en, load_start, load_valid, load_bit;
  logic [7:0]  anim_div;
  logic        load_ready, load_done, busy, stitch;

  int checks   = 0;
  int failures = 0;

  bit mv[$], mh[$], sv[$], sh[$], ld_v[$], ld_h[$];
  int m_cnt;
  bit m_pend;

  logic [0:39] vi = 40'b0110000101001101001110101101010111101101;
  logic [0:21] hi = 22'b1011101001000011010000;

  hitomezashi_gen dut (
    .clk_pix    (clk_pix),
    .rst_pix    (rst_pix),
    .sx         (sx),
    .sy         (sy),
    .frame      (frame),
    .anim_en    (anim_en),
    .anim_div   (anim_div),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_bit   (load_bit),
    .load_ready (load_ready),
    .load_done  (load_done),
    .busy       (busy),
    .stitch     (stitch)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic step();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit m_stitch(input int x, input int y);
    int cx = x / 32;
    int cy = y / 32;
    bit vb = (cx < 40) ? mv[cx] : 1'b0;
    bit hb = (cy < 22) ? mh[cy] : 1'b0;
    bit von = bit'((y / 32) % 2) ^ vb;
    bit hon = bit'((x / 32) % 2) ^ hb;
    return ((x % 32 == 0) && von) || ((y % 32 == 0) && hon);
  endfunction

  task automatic model_reset();
    mv.delete(); mh.delete(); sv.delete(); sh.delete();
    for (int i = 0; i < 40; i++) begin mv.push_back(vi[i]); sv.push_back(1'b0); end
    for (int i = 0; i < 22; i++) begin mh.push_back(hi[i]); sh.push_back(1'b0); end
    m_cnt  = 0;
    m_pend = 0;
  endtask

  task automatic pix(input int x, input int y);
    sx = 12'(x); sy = 12'(y);
    step();
    chk($sformatf("stitch(%0d,%0d)", x, y), stitch, m_stitch(x, y));
  endtask

  task automatic pix_exp(input int x, input int y, input bit e);
    sx = 12'(x); sy = 12'(y);
    step();
    chk($sformatf("stitch_const(%0d,%0d)", x, y), stitch, e);
  endtask

  function automatic int rcoord(input int cells);
    return $urandom_range(0, cells) * 32 + ($urandom_range(0, 1) ? 0 : $urandom_range(0, 31));
  endfunction

  task automatic rand_pix(input int n);
    for (int k = 0; k < n; k++) pix(rcoord(44), rcoord(25));
  endtask

  task automatic do_frame();
    bit exp_done = 1'b0;
    frame = 1'b1;
    step();
    frame = 1'b0;
    if (!anim_en) m_cnt = 0;
    if (m_pend) begin
      mv = sv; mh = sh; m_cnt = 0; m_pend = 0; exp_done = 1'b1;
    end else if (anim_en) begin
      if (m_cnt == int'(anim_div)) begin
        m_cnt = 0;
        mv.push_back(mv.pop_front());
        mh.push_back(mh.pop_front());
      end else m_cnt++;
    end
    chk("load_done_rise", load_done, exp_done);
    if (exp_done) chk("busy_after_commit", busy, 0);
    step();
    chk("load_done_width", load_done, 0);
  endtask

  task automatic rand_vecs();
    ld_v.delete(); ld_h.delete();
    for (int i = 0; i < 40; i++) ld_v.push_back(bit'($urandom_range(0, 1)));
    for (int i = 0; i < 22; i++) ld_h.push_back(bit'($urandom_range(0, 1)));
  endtask

  // frame_at < 0 means no frame pulse during the load
  task automatic do_load(input bit bp, input int frame_at);
    bit all[$];
    all = {ld_v, ld_h};
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("ready_after_start", load_ready, 1);
    for (int i = 0; i < all.size(); i++) begin
      if (i == frame_at) begin
        load_valid = 1'b0;
        do_frame();
        chk("busy_mid_load", busy, 1);
      end
      if (bp && $urandom_range(0, 1) == 1) begin
        load_valid = 1'b0;
        load_bit   = bit'($urandom_range(0, 1));
        step();
      end
      load_valid = 1'b1;
      load_bit   = all[i];
      chk($sformatf("ready_bit%0d", i), load_ready, 1);
      step();
    end
    load_valid = 1'b0;
    sv = ld_v; sh = ld_h; m_pend = 1;
    chk("busy_pend", busy, 1);
    chk("ready_pend", load_ready, 0);
  endtask

  initial begin
    rst_pix = 1'b1; sx = '0; sy = '0; frame = 0; anim_en = 0; anim_div = 8'd2;
    load_start = 0; load_valid = 0; load_bit = 0;
    model_reset();
    step(); step();
    chk("reset_stitch", stitch, 0);
    chk("reset_ready", load_ready, 0);
    chk("reset_done", load_done, 0);
    chk("reset_busy", busy, 0);
    rst_pix = 1'b0;
    pix_exp(0, 0, 1'b1);
    pix_exp(1280, 3, 1'b0);
    pix(4000, 700);
    rand_pix(30);

    // all-ones V, all-zeros H, back-to-back, with a load_start ignored while pending
    ld_v.delete(); ld_h.delete();
    for (int i = 0; i < 40; i++) ld_v.push_back(1'b1);
    for (int i = 0; i < 22; i++) ld_h.push_back(1'b0);
    do_load(1'b0, -1);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("pend_start_ready", load_ready, 0);
    step();
    chk("pend_start_ready2", load_ready, 0);
    chk("pend_start_busy", busy, 1);
    do_frame();
    pix_exp(32, 1, 1'b1);
    pix_exp(1, 0, 1'b0);
    rand_pix(20);

    // random vectors with 50% valid gaps and an early frame that must not commit
    rand_vecs();
    do_load(1'b1, 20);
    rand_pix(5);
    do_frame();
    rand_pix(25);
    do_load(1'b0, -1);
    do_frame();
    rand_pix(15);

    // abort after 10 bits
    rand_vecs();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      load_valid = 1'b1; load_bit = ld_v[i];
      step();
    end
    load_valid = 1'b0;
    rst_pix = 1'b1;
    step();
    rst_pix = 1'b0;
    model_reset();
    chk("abort_busy", busy, 0);
    chk("abort_ready", load_ready, 0);
    chk("abort_stitch", stitch, 0);
    do_frame();
    rand_pix(15);

    // animation every third frame
    anim_en = 1'b1; anim_div = 8'd2;
    pix_exp(0, 1, 1'b0);
    for (int f = 0; f < 3; f++) begin
      do_frame();
      rand_pix(4);
    end
    pix_exp(0, 1, 1'b1);
    pix_exp(1248, 1, 1'b0);
    rand_pix(10);

    // commit and rotation due on the same frame
    do_frame();
    do_frame();
    rand_vecs();
    do_load(1'b0, -1);
    do_frame();
    pix(0, 1);
    pix(1248, 1);
    rand_pix(10);
    for (int f = 0; f < 3; f++) begin
      do_frame();
      pix(0, 1);
      rand_pix(6);
    end

    anim_en = 1'b0;
    do_frame();
    rand_pix(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hitomezashi_gen.md
# hitomezashi_gen

Parametrised Hitomezashi stitch-pattern generator for the racing-the-beam designs. It turns the display controller's `sx`/`sy` into a registered `stitch` pixel flag. The grid size, line counts and start vectors are set by parameters. New start vectors can be loaded at runtime over a valid/ready bit stream, are double-buffered and committed at frame start, and an optional animation mode rotates the pattern every N frames. It sits between the display timing block (e.g. `simple_720p`) and the colour/paint logic.

## Interface
- `CORDW`, 12, screen coordinate width
- `CELL_LOG2`, 5, log2 of cell size in pixels (5 gives a 32 px grid)
- `V_LINES`, 40, number of vertical stitch lines (columns)
- `H_LINES`, 22, number of horizontal stitch lines (rows)
- `V_INIT`, 40'b0110000101001101001110101101010111101101, reset value of the vertical start vector; bit index 0 is the MSB, i.e. column 0
- `H_INIT`, 22'b1011101001000011010000, reset value of the horizontal start vector; row 0 is the MSB
- `ANIMW`, 8, width of the animation divider
- `clk_pix`  in  1  pixel clock; the only clock
- `rst_pix`  in  1  reset, synchronous, active-high
- `sx`, `sy`  in  CORDW  current screen position
- `frame`  in  1  one-cycle pulse at the start of frame
- `anim_en`  in  1  enable pattern rotation
- `anim_div`  in  ANIMW  number of frames between rotations minus 1
- `load_start`  in  1  pulse that begins a vector load
- `load_valid`  in  1  `load_bit` is valid
- `load_bit`  in  1  serial start-vector bit
- `load_ready`  out  1  loader accepts a bit
- `load_done`  out  1  one-cycle pulse when the new vectors become active
- `busy`  out  1  load in progress or waiting to commit
- `stitch`  out  1  pixel is on a stitch line (registered)

## Operation
- Reset (state after any `rst_pix` cycle, including mid-load; any partial load is discarded):
  - active vectors take `V_INIT`/`H_INIT`, shadow vectors are cleared
  - FSM goes to IDLE and the frame counter goes to 0
  - `stitch`, `load_ready`, `load_done` and `busy` are 0
- Pattern:
  - cx = sx >> CELL_LOG2 and cy = sy >> CELL_LOG2
  - v_line = (sx low CELL_LOG2 bits == 0); h_line = (sy low CELL_LOG2 bits == 0)
  - v_on = sy[CELL_LOG2] ^ v_act[cx]; h_on = sx[CELL_LOG2] ^ h_act[cy]
  - Out-of-range indices (cx ≥ V_LINES, cy ≥ H_LINES) read 0. There is no wrap and no out-of-bounds access.
  - stitch = (v_line & v_on) | (h_line & h_on)
- Load FSM, with states IDLE, LOAD_V, LOAD_H and PEND:
  - IDLE: `load_start` moves to LOAD_V and clears the bit counter. `load_start` in any other state is ignored.
  - LOAD_V: `load_ready` = 1. Each accepted bit (valid & ready) is written to shadow_v[count] and the count increments. After bit V_LINES-1 the FSM moves to LOAD_H with count 0.
  - LOAD_H: same as LOAD_V, filling shadow_h. After bit H_LINES-1 the FSM moves to PEND.
  - PEND: `load_ready` = 0. On `frame`, shadow is copied to active, `load_done` pulses, the frame counter is cleared and the FSM returns to IDLE.
  - `busy` = 1 in LOAD_V, LOAD_H and PEND.
  - `load_valid` while not ready is ignored.
- Animation:
  - When `anim_en` is set, each `frame` increments the frame counter.
  - When counter == `anim_div`, the counter goes to 0 and both active vectors rotate left by 1: column 0 takes the old column 1 value, and the old column 0 value wraps to the last position.
  - When `anim_en` is clear, the counter holds at 0.
  - Commit and rotation due on the same `frame`: commit wins, there is no rotation, and the counter is cleared.
- Active vectors change only on a `frame` cycle, so a frame never tears.

## Timing
- `stitch` has 1 cycle of latency from `sx`/`sy`. The caller delays `de`/syncs by 1 to match.
- A vector change on the `frame` cycle N takes effect on `stitch` from cycle N+2, i.e. the pixel presented at N+1.
- Full load: V_LINES+H_LINES accepted bits, plus the wait for the next `frame`.
- Minimum load: with back-to-back valid bits, `load_start` at T gives `load_ready` from T+1. A `frame` at or after T+1+V_LINES+H_LINES commits.
- A `frame` arriving before PEND is not a commit; the commit waits for the next one.
- `load_done` rises in the cycle after the committing `frame` and lasts exactly 1 cycle.

## Structure
- Package `hitomezashi_pkg`:
  - typedef `load_state_t` (IDLE, LOAD_V, LOAD_H, PEND)
  - the default `V_INIT`/`H_INIT` constants
- One sub-module, `hitomezashi_loader`: the FSM, bit counter and shadow registers. It outputs the shadow vectors and a commit strobe.
- The top level holds the active vectors, the animation counter and the pixel datapath.

## Test plan
- Reset defaults: sx=0, sy=0 gives `stitch`=0, because v_act[0]=0 and sy[5]=0, and h_act[0]=1 XOR sx[5]=0 would be 1 but is masked by reset. The cycle after release with sx=0, sy=0 gives `stitch`=1, from h_line with h_on = 0^1.
- Full load of all-ones V and all-zeros H, then `frame`:
  - `load_done` pulses once
  - sx=32, sy=1 gives `stitch`=1
  - sx=1, sy=0 gives 0
  - `busy` falls at commit
- Backpressure and abort:
  - `load_valid` toggling 50% gives identical vectors to a back-to-back load
  - `rst_pix` after 10 bits gives `busy`=0 and active = `V_INIT`
- Animation with `anim_en`=1 and `anim_div`=2: rotation on every 3rd `frame`. After one rotation, column 0 shows old `V_INIT` bit 1 and the last column shows old bit 0.
- Commit and rotation due on the same `frame`: the new vectors appear unrotated and the counter reads 0.
- Boundary: sx ≥ V_LINES·32 (e.g. 1280) with sy=3 gives no vertical stitch. A `load_start` while PEND is ignored and `load_ready` stays 0.
